// File: rtl/stream_uart_bridge.sv
// CPU byte interface <-> ready/valid link bridge with a TX FIFO plus output stage and an RX FIFO.
// Optional internal TX->RX loopback: define STREAM_UART_BRIDGE_LOOPBACK_EN.

module stream_uart_bridge_fifo #(
    parameter int DW = 8,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] head,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);
    localparam int LW = AW + 1;
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;
    logic [AW:0]   level_reg;

    // Storage carries no reset so it can map onto RAM; validity is tracked by level_reg.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            level_reg <= '0;
        end else if (flush) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            level_reg <= '0;
        end else begin
            if (push) begin
                wptr_reg <= wptr_reg + AW'(1);
            end
            if (pop) begin
                rptr_reg <= rptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign head  = mem[rptr_reg];
    assign level = level_reg;
    assign full  = (level_reg == LW'(DEPTH));
    assign empty = (level_reg == '0);
endmodule

module stream_uart_bridge #(
    parameter int DATA_WIDTH   = 8,
    parameter int LOG2_DEPTH   = 6,
    parameter int TX_LOW_MARK  = 8,
    parameter int RX_HIGH_MARK = 48
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef STREAM_UART_BRIDGE_LOOPBACK_EN
    input  logic                  loopback,
`endif
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_we,
    input  logic                  cpu_rd,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  tx_full,
    output logic                  rx_empty,
    output logic [LOG2_DEPTH:0]   tx_level,
    output logic [LOG2_DEPTH:0]   rx_level,
    input  logic                  flush_tx,
    input  logic                  flush_rx,
    output logic                  irq_tx_low,
    output logic                  irq_rx_high,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic [DATA_WIDTH-1:0] link_tx_data,
    output logic                  link_tx_valid,
    input  logic                  link_tx_ready,
    input  logic [DATA_WIDTH-1:0] link_rx_data,
    input  logic                  link_rx_valid,
    output logic                  link_rx_ready
);
    localparam int LW    = LOG2_DEPTH + 1;
    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam int TX_MARK_I = (TX_LOW_MARK < 0) ? 0 : ((TX_LOW_MARK > DEPTH) ? DEPTH : TX_LOW_MARK);
    localparam int RX_MARK_I = (RX_HIGH_MARK < 0) ? 0 : ((RX_HIGH_MARK > DEPTH) ? DEPTH : RX_HIGH_MARK);
    localparam logic [LOG2_DEPTH:0] TX_MARK = LW'(TX_MARK_I);
    localparam logic [LOG2_DEPTH:0] RX_MARK = LW'(RX_MARK_I);

    logic lb;
`ifdef STREAM_UART_BRIDGE_LOOPBACK_EN
    assign lb = loopback;
`else
    assign lb = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] tx_head;
    logic [DATA_WIDTH-1:0] rx_head;
    logic [DATA_WIDTH-1:0] rx_wdata;
    logic                  tx_empty;
    logic                  rx_full;
    logic                  tx_push;
    logic                  tx_pop;
    logic                  rx_push;
    logic                  rx_pop;
    logic                  stage_take;
    logic                  stage_free;

    logic                  stage_valid_reg;
    logic [DATA_WIDTH-1:0] stage_data_reg;
    logic [DATA_WIDTH-1:0] cpu_rdata_reg;
    logic                  overflow_reg;

    // A same-cycle pop never frees space for the write: tx_full is the registered view.
    assign tx_push = cpu_we && !tx_full && !flush_tx;

    // In loopback the stage drains into RX; it is held while RX is flushing so no word is lost.
    assign stage_take = stage_valid_reg && (lb ? (!rx_full && !flush_rx) : link_tx_ready);
    assign stage_free = !stage_valid_reg || stage_take;
    assign tx_pop     = stage_free && !tx_empty && !flush_tx;

    assign rx_push  = (lb ? stage_valid_reg : link_rx_valid) && !rx_full && !flush_rx;
    assign rx_wdata = lb ? stage_data_reg : link_rx_data;
    assign rx_pop   = cpu_rd && !rx_empty && !flush_rx;

    stream_uart_bridge_fifo #(
        .DW(DATA_WIDTH),
        .AW(LOG2_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (flush_tx),
        .wdata (cpu_wdata),
        .head  (tx_head),
        .level (tx_level),
        .full  (tx_full),
        .empty (tx_empty)
    );

    stream_uart_bridge_fifo #(
        .DW(DATA_WIDTH),
        .AW(LOG2_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (flush_rx),
        .wdata (rx_wdata),
        .head  (rx_head),
        .level (rx_level),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid_reg <= 1'b0;
            stage_data_reg  <= '0;
        end else if (flush_tx) begin
            stage_valid_reg <= 1'b0;
        end else if (stage_free) begin
            stage_valid_reg <= !tx_empty;
            if (!tx_empty) begin
                stage_data_reg <= tx_head;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            if (rx_pop) begin
                cpu_rdata_reg <= rx_head;
            end
            if (cpu_we && tx_full && !flush_tx) begin
                overflow_reg <= 1'b1;
            end else if (clr_overflow) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign cpu_rdata     = cpu_rdata_reg;
    assign overflow      = overflow_reg;
    assign link_tx_data  = stage_data_reg;
    assign link_tx_valid = stage_valid_reg && !lb;
    assign link_rx_ready = !rx_full && !lb;
    assign irq_tx_low    = (tx_level <= TX_MARK);
    assign irq_rx_high   = (rx_level >= RX_MARK);
endmodule
